tt_scanner: RTL

- Sequential truth-table reader for the combinational minimal-logic blocks (4-input POS/SOP functions F(A,B,C,D)).
- Drives every input combination onto a function under test, waits a settle interval, then samples F.
- Builds a 2^N-bit truth table and a count of ones, and compares the table against an expected table.
- Used on-board and in benches as the self-checking counterpart of the function blocks.

---
 rtl/tt_scanner_pkg.sv | 24 ++
 rtl/tt_scanner_if.sv | 29 ++
 rtl/tt_scanner.sv | 110 +++++++++++
 3 files changed

// File: rtl/tt_scanner_pkg.sv
// Shared types and sizing helpers for the truth-table scanner.
// Imported by the scanner interface and the scanner core.
package tt_scanner_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  localparam int unsigned N_IN_DEF = 4;
  localparam int unsigned N_VEC    = 1 << N_IN_DEF;

  function automatic int unsigned n_vec(input int unsigned n_in);
    return 1 << n_in;
  endfunction

  // One extra bit so an all-ones table (2^n_in) fits without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/tt_scanner_if.sv
// Signal bundle between a scanner and the function under test / controller.
// The master side requests scans and drives F; the slave side is the scanner.
interface tt_scanner_if
  import tt_scanner_pkg::*;
#(
  parameter int unsigned N_IN = N_IN_DEF
);

  logic                    start;
  logic [n_vec(N_IN)-1:0]  exp_tbl;
  logic                    f_in;
  logic [N_IN-1:0]         vec_out;
  logic                    busy;
  logic                    done;
  logic [n_vec(N_IN)-1:0]  truth_tbl;
  logic [cnt_width(N_IN)-1:0] ones_cnt;
  logic                    match;

  modport master (
    output start, exp_tbl, f_in,
    input  vec_out, busy, done, truth_tbl, ones_cnt, match
  );

  modport slave (
    input  start, exp_tbl, f_in,
    output vec_out, busy, done, truth_tbl, ones_cnt, match
  );

endinterface

// File: rtl/tt_scanner.sv
// Sequential truth-table reader: steps every input vector, waits SETTLE cycles,
// samples F, and compares the finished table against an expected one.
module tt_scanner
  import tt_scanner_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned SETTLE = 1  // legal range 1..15
) (
  input logic         clk,
  input logic         rst_n,
  tt_scanner_if.slave bus
);

  localparam int unsigned NVec     = n_vec(N_IN);
  localparam int unsigned CntW     = cnt_width(N_IN);
  localparam logic [3:0]  WaitLast = 4'(SETTLE - 1);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [3:0]          wait_q, wait_d;
  logic [NVec-1:0]     tbl_q, tbl_d, tbl_wr;
  logic [CntW-1:0]     ones_q, ones_d;
  logic                match_q, match_d;
  logic                last_vec;
  logic                settled;

  assign last_vec = (vec_q == {N_IN{1'b1}});
  assign settled  = (wait_q == WaitLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      wait_q  <= '0;
      tbl_q   <= '0;
      ones_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      tbl_q   <= tbl_d;
      ones_q  <= ones_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StSettle;
      StSettle: if (settled) state_d = StSample;
      StSample: state_d = last_vec ? StDone : StSettle;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    vec_d   = vec_q;
    wait_d  = wait_q;
    tbl_d   = tbl_q;
    ones_d  = ones_q;
    match_d = match_q;
    // Table as it will be once this cycle's sample lands; match must see it.
    tbl_wr         = tbl_q;
    tbl_wr[vec_q]  = bus.f_in;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          vec_d   = '0;
          wait_d  = '0;
          tbl_d   = '0;
          ones_d  = '0;
          match_d = 1'b0;
        end
      end
      StSettle: begin
        if (!settled) wait_d = wait_q + 4'd1;
      end
      StSample: begin
        tbl_d  = tbl_wr;
        ones_d = ones_q + CntW'(bus.f_in);
        if (last_vec) begin
          match_d = (tbl_wr == bus.exp_tbl);
        end else begin
          vec_d  = vec_q + N_IN'(1);
          wait_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      StSettle, StSample: bus.busy = 1'b1;
      StDone:             bus.done = 1'b1;
      default:            ;
    endcase
  end

  assign bus.vec_out   = vec_q;
  assign bus.truth_tbl = tbl_q;
  assign bus.ones_cnt  = ones_q;
  assign bus.match     = match_q;

endmodule
